// File: rtl/mem_req_initiator.sv
// rtl/mem_req_initiator.sv - per-core memory requestor: command FIFO, req/resp handshake, timeout; retry via MEM_REQ_RETRY_EN
module mem_req_initiator #(
  parameter int DATA_SIZE      = 2,
  parameter int ADDR_W         = 14,
  parameter int QUEUE_DEPTH    = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_RETRIES    = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic [DATA_SIZE*8-1:0] cmd_wdata,
  output logic                   rsp_valid,
  output logic                   rsp_write,
  output logic [DATA_SIZE*8-1:0] rsp_rdata,
  output logic                   rsp_error,
  output logic                   processor_req,
  output logic                   mem_read_req,
  output logic                   mem_write_req,
  output logic [ADDR_W-1:0]      addr,
  output logic [DATA_SIZE*8-1:0] mem_write_data,
  input  logic [DATA_SIZE*8-1:0] mem_read_data,
  input  logic                   processor_resp,
  output logic                   busy
);

  localparam int DW = DATA_SIZE * 8;
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int EW = 1 + ADDR_W + DW;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0 || MAX_RETRIES < 0) begin : g_bad_params
    $error("mem_req_initiator: QUEUE_DEPTH must be a power of 2 >= 2 and MAX_RETRIES >= 0");
  end

  // Command FIFO: pointers carry one wrap bit so full and empty are distinguishable.
  logic [EW-1:0] fifo_mem [QUEUE_DEPTH];
  logic [PW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          fifo_empty, fifo_full, push, pop;
  logic [EW-1:0] fifo_head;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;

  logic          req_write_q, req_write_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DW-1:0] req_wdata_q, req_wdata_d;

  logic          rsp_fire, rsp_err;
  logic          reissue;

  logic          processor_req_q, mem_read_req_q, mem_write_req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DW-1:0] mem_write_data_q;
  logic          rsp_valid_q, rsp_write_q, rsp_error_q;
  logic [DW-1:0] rsp_rdata_q;

`ifdef MEM_REQ_RETRY_EN
  localparam int RW = $clog2(MAX_RETRIES + 2);
  logic [RW-1:0] retry_q, retry_d;
  logic          reissue_q, reissue_d;
  assign reissue = reissue_q;
`else
  assign reissue = 1'b0;
`endif

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  assign fifo_head  = fifo_mem[rd_ptr_q[PW-1:0]];
  assign wr_ptr_d   = wr_ptr_q + (PW+1)'(push);
  assign rd_ptr_d   = rd_ptr_q + (PW+1)'(pop);

  // Request registers load the FIFO head on pop and hold it through retries.
  assign req_write_d = pop ? fifo_head[EW-1]          : req_write_q;
  assign req_addr_d  = pop ? fifo_head[DW +: ADDR_W]  : req_addr_q;
  assign req_wdata_d = pop ? fifo_head[DW-1:0]        : req_wdata_q;

  // FIFO storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[PW-1:0]] <= {cmd_write, cmd_addr, cmd_wdata};
  end

  // Handshake FSM next-state, timer and completion decode.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    rsp_fire = 1'b0;
    rsp_err  = 1'b0;
`ifdef MEM_REQ_RETRY_EN
    retry_d   = retry_q;
    reissue_d = reissue_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = S_WAIT;
          timer_d = '0;
`ifdef MEM_REQ_RETRY_EN
          retry_d = '0;
`endif
        end
      end
      S_WAIT: begin
        if (processor_resp) begin
          state_d  = S_RELEASE;
          timer_d  = '0;
          rsp_fire = 1'b1;
        end else if (timer_q == T_LAST) begin
          state_d = S_RELEASE;
          timer_d = '0;
`ifdef MEM_REQ_RETRY_EN
          if (retry_q < RW'(MAX_RETRIES)) begin
            retry_d   = retry_q + 1'b1;
            reissue_d = 1'b1;
          end else begin
            rsp_fire = 1'b1;
            rsp_err  = 1'b1;
          end
`else
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
`endif
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RELEASE: begin
        // Wait for resp to drop so a lingering level is never read as the next grant.
        if (!processor_resp || timer_q == T_LAST) begin
          state_d = reissue ? S_WAIT : S_IDLE;
          timer_d = '0;
`ifdef MEM_REQ_RETRY_EN
          reissue_d = 1'b0;
`endif
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, pointers and request registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
    end
  end

`ifdef MEM_REQ_RETRY_EN
  // Retry bookkeeping: attempts made for the held command and pending reissue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retry_q   <= '0;
      reissue_q <= 1'b0;
    end else begin
      retry_q   <= retry_d;
      reissue_q <= reissue_d;
    end
  end
`endif

  // Memory-side outputs registered from the next state so they are glitch-free and stable in WAIT_RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      processor_req_q  <= 1'b0;
      mem_read_req_q   <= 1'b0;
      mem_write_req_q  <= 1'b0;
      addr_q           <= '0;
      mem_write_data_q <= '0;
    end else begin
      processor_req_q  <= (state_d == S_WAIT);
      mem_read_req_q   <= (state_d == S_WAIT) && !req_write_d;
      mem_write_req_q  <= (state_d == S_WAIT) && req_write_d;
      addr_q           <= (state_d == S_WAIT) ? req_addr_d  : '0;
      mem_write_data_q <= (state_d == S_WAIT) ? req_wdata_d : '0;
    end
  end

  // Response pulse; payload holds its last value between pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rsp_fire;
      if (rsp_fire) begin
        rsp_write_q <= req_write_q;
        rsp_error_q <= rsp_err;
        rsp_rdata_q <= (rsp_err || req_write_q) ? '0 : mem_read_data;
      end
    end
  end

  assign processor_req  = processor_req_q;
  assign mem_read_req   = mem_read_req_q;
  assign mem_write_req  = mem_write_req_q;
  assign addr           = addr_q;
  assign mem_write_data = mem_write_data_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_write      = rsp_write_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_error      = rsp_error_q;
  assign busy           = !fifo_empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_req_initiator.sv
// tb/tb_mem_req_initiator.sv - randomized bench with transaction-level model and memory responder for mem_req_initiator
module tb_mem_req_initiator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [13:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid, rsp_write, rsp_error;
  logic [15:0] rsp_rdata;
  logic        processor_req, mem_read_req, mem_write_req;
  logic [13:0] addr;
  logic [15:0] mem_write_data, mem_read_data;
  logic        processor_resp;
  logic        busy;

`ifdef MEM_REQ_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  mem_req_initiator dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .processor_req(processor_req), .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
    .addr(addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .processor_resp(processor_resp), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          write;
    logic [13:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          delay;
    int          hold;
    bit          never;
  } cmd_t;

  cmd_t exp_q[$];
  int n_vec = 0, n_fail = 0;
  int cyc = 0, acc_cyc = 0, rise_cyc = 0, last_rsp_cyc = 0, gap_last = 0;
  int attempts = 0, m_cnt = 0, hold_left = 0, rsp_count = 0;
  bit prev_req = 0, resp_d1 = 0;
  bit last_write, last_err;
  logic [15:0] last_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle checker and memory responder, both driven from the command-level model.
  always @(negedge clk) begin
    cmd_t h;
    bit rise;
    cyc = cyc + 1;
    resp_d1 = processor_resp;
    if (!reset_n) begin
      processor_resp = 1'b0;
      hold_left = 0; prev_req = 0; attempts = 0; m_cnt = 0;
    end else begin
      if (rsp_valid) begin
        rsp_count++;
        if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          h = exp_q.pop_front();
          chk("rsp_write", rsp_write, h.write);
          chk("rsp_error", rsp_error, h.never);
          chk("rsp_rdata", rsp_rdata, (h.write || h.never) ? 16'h0 : h.rdata);
          chk("rsp_latency", cyc - rise_cyc, h.never ? 64 : h.delay + 1);
          chk("rsp_attempts", attempts, h.never ? ATTEMPTS : 1);
          last_write = rsp_write; last_err = rsp_error; last_rdata = rsp_rdata;
          last_rsp_cyc = cyc;
          attempts = 0;
        end
      end
      rise = processor_req && !prev_req;
      if (processor_req) begin
        if (exp_q.size() == 0) begin
          if (rise) chk("issue_unexpected", 1, 0);
        end else begin
          h = exp_q[0];
          if (rise) begin
            chk("issue_after_stale_resp", resp_d1, 0);
            rise_cyc = cyc; attempts++; m_cnt = 0;
            gap_last = cyc - last_rsp_cyc;
          end else m_cnt++;
          chk("mem_write_req", mem_write_req, h.write);
          chk("mem_read_req", mem_read_req, !h.write);
          chk("addr", addr, h.addr);
          chk("mem_write_data", mem_write_data, h.wdata);
        end
      end else begin
        chk("idle_outputs", {mem_read_req, mem_write_req, addr, mem_write_data}, 0);
      end
      if (hold_left > 0) begin processor_resp = 1'b1; hold_left--; end
      else processor_resp = 1'b0;
      mem_read_data = 16'($urandom);
      if (processor_req && exp_q.size() > 0) begin
        h = exp_q[0];
        if (!h.never && m_cnt == h.delay) begin
          processor_resp = 1'b1;
          hold_left = h.hold - 1;
          if (!h.write) mem_read_data = h.rdata;
        end
      end
      prev_req = processor_req;
    end
  end

  // Present one command; returns at posedge+1 after it was accepted.
  task automatic push(input bit w, input logic [13:0] a, input logic [15:0] d,
                      input logic [15:0] rd, input int dl, input int hd, input bit nv);
    cmd_t e;
    int n;
    e.write = w; e.addr = a; e.wdata = d; e.rdata = rd; e.delay = dl; e.hold = hd; e.never = nv;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    n = 0;
    forever begin
      @(negedge clk); #2;
      if (cmd_ready) begin exp_q.push_back(e); acc_cyc = cyc; break; end
      n++;
      if (n > 3000) begin chk("push_timeout", 1, 0); break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 || busy) begin
      idle(1);
      n++;
      if (n > 5000) begin chk("drain_timeout", 1, 0); break; end
    end
  endtask

  initial begin
    int snap, n;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    processor_resp = 1'b0; mem_read_data = '0;
    #13;
    chk("reset_processor_req", processor_req, 0);
    chk("reset_mem_reqs", {mem_read_req, mem_write_req}, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_cmd_ready", cmd_ready, 1);
    #10 reset_n = 1'b1;
    idle(2);

    // Single write, immediate response
    push(1, 14'h0005, 16'h1234, 16'h0, 0, 1, 0);
    wait_idle();
    chk("wr_latency", last_rsp_cyc - acc_cyc, 3);
    chk("wr_rsp_write", last_write, 1);
    chk("wr_rsp_error", last_err, 0);
    chk("wr_rsp_rdata", last_rdata, 16'h0);

    // Read at top address
    push(0, 14'h3FFF, 16'hBEEF, 16'h4000, 0, 1, 0);
    wait_idle();
    chk("rd_rsp_rdata", last_rdata, 16'h4000);
    chk("rd_rsp_write", last_write, 0);
    chk("rd_rsp_error", last_err, 0);

    // A withheld, B and C fill the FIFO
    push(0, 14'h0A0A, 16'h0, 16'hAAAA, 12, 1, 0);
    push(1, 14'h0B0B, 16'hBBBB, 16'h0, 0, 1, 0);
    push(0, 14'h0C0C, 16'h0, 16'hCCCC, 2, 1, 0);
    chk("fifo_full_cmd_ready", cmd_ready, 0);
    chk("fifo_full_busy", busy, 1);
    n = 0;
    while (!(exp_q.size() == 2 && processor_req)) begin
      idle(1); n++;
      if (n > 200) begin chk("b_issue_timeout", 1, 0); break; end
    end
    chk("after_b_pop_cmd_ready", cmd_ready, 1);
    wait_idle();
    chk("c_last_rdata", last_rdata, 16'hCCCC);

    // Memory never answers
    push(0, 14'h1111, 16'h0, 16'h5555, 0, 1, 1);
    wait_idle();
    chk("to_error", last_err, 1);
    chk("to_rdata", last_rdata, 16'h0);
    chk("to_latency", last_rsp_cyc - rise_cyc, 64);

    // Resp held for 5 cycles, next command queued behind it
    push(1, 14'h0123, 16'h9876, 16'h0, 0, 5, 0);
    push(0, 14'h0321, 16'h0, 16'h6789, 1, 1, 0);
    wait_idle();
    chk("stale_gap", gap_last, 6);
    chk("stale_next_rdata", last_rdata, 16'h6789);

    // Reset while a command is in flight with two queued
    push(0, 14'h2222, 16'h0, 16'h1, 0, 1, 1);
    push(1, 14'h3333, 16'h7777, 16'h0, 0, 1, 0);
    push(1, 14'h3334, 16'h7778, 16'h0, 0, 1, 0);
    idle(3);
    chk("pre_reset_req", processor_req, 1);
    @(negedge clk); #3;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_processor_req", processor_req, 0);
    chk("arst_mem_reqs", {mem_read_req, mem_write_req}, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cmd_ready", cmd_ready, 1);
    #20 reset_n = 1'b1;
    idle(1);
    snap = rsp_count;
    idle(100);
    chk("no_rsp_after_reset", rsp_count - snap, 0);
    chk("post_reset_req", processor_req, 0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      bit nv;
      nv = ($urandom_range(0, 9) == 0);
      push(1'($urandom), 14'($urandom), 16'($urandom), 16'($urandom),
           $urandom_range(0, 6), $urandom_range(1, 4), nv);
      idle($urandom_range(0, 3));
    end
    wait_idle();
    chk("end_busy", busy, 0);
    chk("end_cmd_ready", cmd_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_req_initiator.md
Name: mem_req_initiator

Overview:
- Processor-side requestor port for memory_subsystem. One instance per core, driving one of the four processor_req_N / mem_*_req_N / addr_N / mem_write_data_N port groups.
- Accepts read/write commands from the core through a valid/ready interface and buffers them in a small in-order FIFO.
- Runs the req/resp handshake against the shared memory, with a timeout.
- Returns one response per command: read data plus an error flag.

Parameters:
DATA_SIZE, 2, bytes per memory word; data width is DATA_SIZE*8
ADDR_W, 14, memory word address width
QUEUE_DEPTH, 2, command FIFO entries (power of 2, ≥2)
TIMEOUT_CYCLES, 64, cycles in WAIT_RESP without processor_resp before timeout
MAX_RETRIES, 2, reissues after timeout (used only with MEM_REQ_RETRY_EN)

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  core presents a command
cmd_ready  out  1  command FIFO not full
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  word address
cmd_wdata  in  DATA_SIZE*8  write data
rsp_valid  out  1  one-cycle pulse: command completed
rsp_write  out  1  type of the completed command
rsp_rdata  out  DATA_SIZE*8  read data; 0 for writes or errors
rsp_error  out  1  command timed out
processor_req  out  1  to memory_subsystem processor_req_N
mem_read_req  out  1  to mem_read_req_N
mem_write_req  out  1  to mem_write_req_N
addr  out  ADDR_W  to addr_N
mem_write_data  out  DATA_SIZE*8  to mem_write_data_N
mem_read_data  in  DATA_SIZE*8  from mem_read_data_N
processor_resp  in  1  from processor_resp_N (memory updates it on falling edge)
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (asynchronous, any state):
  - FSM returns to IDLE; FIFO is emptied; timer and retry count clear.
  - All memory-side outputs, rsp_* and busy are 0; cmd_ready is 1.
  - An in-flight command is dropped with no response.
- FIFO:
  - Push when cmd_valid && cmd_ready; cmd_ready = !full.
  - Pop only in IDLE. Push and pop in the same cycle are both allowed.
  - Commands complete strictly in order.
- FSM states: IDLE, WAIT_RESP, RELEASE.
- IDLE:
  - If FIFO is non-empty: pop the head into internal request registers, clear timer, go to WAIT_RESP.
  - Memory-side outputs are 0 in IDLE.
- WAIT_RESP:
  - Outputs are registered from the request registers: processor_req=1, exactly one of mem_read_req/mem_write_req=1, addr, mem_write_data.
  - These outputs are held stable for the whole state.
  - Timer increments each cycle.
  - On a rising edge sampling processor_resp=1: capture mem_read_data (reads; 0 for writes), pulse rsp_valid next cycle with rsp_error=0, go to RELEASE.
  - If timer reaches TIMEOUT_CYCLES-1 with processor_resp=0: pulse rsp_valid with rsp_error=1 and rsp_rdata=0, go to RELEASE.
- RELEASE:
  - All memory-side outputs are 0.
  - Stay until processor_resp is sampled 0, then go to IDLE. This prevents a stale level resp from being taken as the next grant.
  - If processor_resp is still 1 after TIMEOUT_CYCLES cycles, go to IDLE anyway; no extra response is issued.
- Latency: cmd accepted at edge N with FSM idle and FIFO empty → requests asserted after edge N+1 → earliest rsp_valid high after edge N+2. Minimum throughput is one command per 3 cycles (IDLE, WAIT_RESP, RELEASE).
- rsp_* has no backpressure; the consumer must take every pulse. rsp_write/rsp_rdata/rsp_error are valid only while rsp_valid=1 and hold their values otherwise.
- Address and data pass through unmodified; no arithmetic.

Optional Feature:
- Macro: MEM_REQ_RETRY_EN.
- Defined: on timeout in WAIT_RESP with retry count < MAX_RETRIES, no response is issued. Retry count increments, FSM goes through RELEASE, then returns to WAIT_RESP with the same held command (not a FIFO pop) and the timer cleared.
- Error response only after MAX_RETRIES+1 attempts all time out. Retry count clears on every new pop.
- Undefined: the first timeout produces the error response immediately; no retry counter exists.

Test Plan:
- Reset asserted mid-WAIT_RESP with 2 commands queued → processor_req, mem_*_req, rsp_valid, busy = 0 asynchronously; cmd_ready=1; no response for dropped commands after release.
- Write addr=0x0005 wdata=0x1234; memory model asserts resp on next falling edge → addr=0x0005, mem_write_data=0x1234, mem_write_req=1 for 1 cycle; rsp_valid pulse with rsp_write=1, rsp_error=0, rsp_rdata=0, 2 cycles after acceptance.
- Read addr=0x3FFF; model returns 0x4000 with resp → rsp_rdata=0x4000, rsp_write=0, rsp_error=0; mem_read_req=1 and mem_write_req=0 throughout.
- Push A, B, C on consecutive cycles, model withholds resp → A issued, B and C fill FIFO, cmd_ready=0 for D. Then release resp → responses in order A, B, C, and cmd_ready returns to 1 after B pops.
- Model never responds, macro off → rsp_valid with rsp_error=1, rsp_rdata=0 exactly 64 cycles after processor_req rises. Macro on → processor_req rises 3 times, error only after the third timeout.
- Model holds resp=1 for 5 cycles after grant, next command queued → processor_req stays 0 until resp sampled low, then reissues.
